// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues I2C transactions, issues them to the controller, retries NACKs, reports results.
// Ports: cmd_* push commands into a DEPTH-entry FIFO (cmd_valid/cmd_ready); rsp_* present one result
// per command (rsp_valid/rsp_ready); ctl_* drive and observe the I2C controller (start/busy handshake).
// Optional: define I2C_SEQ_TIMEOUT_EN for a per-attempt watchdog with a bus-clear (FLUSH) path.
module i2c_cmd_sequencer #(
    parameter int NUM_BYTES      = 1,
    parameter int DEPTH          = 4,
    parameter int MAX_RETRY      = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic                   cmd_len,
    input  logic [6:0]             cmd_addr,
    input  logic [8*NUM_BYTES-1:0] cmd_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [8*NUM_BYTES-1:0] rsp_data,
    output logic                   rsp_nack,
    output logic [1:0]             rsp_tries,
    output logic                   rsp_timeout,
    output logic                   ctl_start,
    output logic                   ctl_op,
    output logic                   ctl_len,
    output logic [6:0]             ctl_addr,
    output logic [8*NUM_BYTES-1:0] ctl_data,
    output logic                   ctl_force_clk,
    input  logic                   ctl_busy,
    input  logic                   ctl_nack,
    input  logic [8*NUM_BYTES-1:0] ctl_q_rx
);
    localparam int DW = 8 * NUM_BYTES;
    localparam int EW = DW + 9;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_DONE, GAP, FLUSH, REPORT} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            op_q, op_d, len_q, len_d;
    logic [6:0]      addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      retry_q, retry_d;
    logic [15:0]     gap_q, gap_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_nack_q, rsp_nack_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]      rsp_tries_q, rsp_tries_d;
    logic            push, pop;

    // cmd_ready comes from the registered count only, so a same-cycle pop never frees a slot early
    assign cmd_ready = count_q != (AW+1)'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign wr_ptr_d  = wr_ptr_q + AW'(push);
    assign rd_ptr_d  = rd_ptr_q + AW'(pop);
    assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    // start drops combinationally in the cycle busy is seen high
    assign ctl_start = (state_q == ISSUE) && !ctl_busy;
    assign ctl_op    = op_q;
    assign ctl_len   = len_q;
    assign ctl_addr  = addr_q;
    assign ctl_data  = data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_nack  = rsp_nack_q;
    assign rsp_tries = rsp_tries_q;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_q, wd_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    assign ctl_force_clk = state_q == FLUSH;
    assign rsp_timeout   = rsp_timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign ctl_force_clk  = 1'b0;
    assign rsp_timeout    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        {op_d, len_d, addr_d, data_d} = {op_q, len_q, addr_q, data_q};
        retry_d     = retry_q;
        gap_d       = gap_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_nack_d  = rsp_nack_q;
        rsp_tries_d = rsp_tries_q;
        pop         = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        wd_d          = wd_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            IDLE: if (count_q != '0 && !ctl_busy) begin
                pop     = 1'b1;
                {op_d, len_d, addr_d, data_d} = mem_q[rd_ptr_q];
                retry_d = '0;
                state_d = LOAD;
            end
            LOAD:  state_d = ISSUE;
            ISSUE: if (ctl_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!ctl_busy) begin
                if (!ctl_nack || retry_q == 2'(MAX_RETRY)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = op_q ? ctl_q_rx : '0;
                    rsp_nack_d  = ctl_nack;
                    rsp_tries_d = retry_q;
`ifdef I2C_SEQ_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d     = REPORT;
                end else begin
                    retry_d = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: if (gap_q == 16'(GAP_CYCLES - 1)) state_d = ISSUE;
                 else gap_d = gap_q + 16'd1;
            FLUSH: ;
            REPORT: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef I2C_SEQ_TIMEOUT_EN
        if (state_q == ISSUE || state_q == WAIT_DONE || state_q == FLUSH) wd_d = wd_q + 16'd1;
        // a normal completion in the same cycle as expiry wins over the watchdog
        if ((state_q == ISSUE || (state_q == WAIT_DONE && ctl_busy)) && wd_q == TO_LIM) begin
            state_d = FLUSH;
            wd_d    = '0;
        end
        if (state_q == FLUSH && (!ctl_busy || wd_q == TO_LIM)) begin
            rsp_valid_d   = 1'b1;
            rsp_data_d    = '0;
            rsp_nack_d    = 1'b1;
            rsp_tries_d   = retry_q;
            rsp_timeout_d = 1'b1;
            state_d       = REPORT;
        end
        if (state_d == ISSUE && state_q != ISSUE) wd_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_q        <= 1'b0;
            len_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            retry_q     <= '0;
            gap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_nack_q  <= 1'b0;
            rsp_tries_q <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            wd_q          <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_q        <= op_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            retry_q     <= retry_d;
            gap_q       <= gap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_nack_q  <= rsp_nack_d;
            rsp_tries_q <= rsp_tries_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            wd_q          <= wd_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_len, cmd_addr, cmd_data};
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: scoreboard bench with a behavioural I2C controller model for i2c_cmd_sequencer.
module tb_i2c_cmd_sequencer;
    localparam int DEPTH = 4, MAX_RETRY = 2, GAP = 16, TO = 64;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0, cmd_len = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_nack, rsp_timeout;
    logic [7:0] rsp_data;
    logic [1:0] rsp_tries;
    logic       ctl_start, ctl_op, ctl_len, ctl_force_clk;
    logic [6:0] ctl_addr;
    logic [7:0] ctl_data;
    logic       ctl_busy = 1'b0, ctl_nack = 1'b0;
    logic [7:0] ctl_q_rx = '0;

    i2c_cmd_sequencer #(.NUM_BYTES(1), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY),
                        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .rsp_tries(rsp_tries), .rsp_timeout(rsp_timeout),
        .ctl_start(ctl_start), .ctl_op(ctl_op), .ctl_len(ctl_len), .ctl_addr(ctl_addr),
        .ctl_data(ctl_data), .ctl_force_clk(ctl_force_clk),
        .ctl_busy(ctl_busy), .ctl_nack(ctl_nack), .ctl_q_rx(ctl_q_rx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        logic       len;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] rx;
        int         nack_n;
        int         busy_len;
    } plan_t;

    typedef struct {
        logic [7:0] data;
        logic       nack;
        logic [1:0] tries;
        logic       timeout;
    } rsp_t;

    plan_t plans[$];
    rsp_t  exp_q[$];
    int    n_chk = 0, n_fail = 0;
    int    cyc = 0, push_cyc = 0, start_cyc = 0, last_fall = 0, n_starts = 0;
    int    ready_mode = 1;
    bit    hold = 0, held = 0, have_cur = 0, this_nack = 0;
    plan_t cur;
    int    rem = 0, att = 0;
    rsp_t  mon_e;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Result a command should produce, straight from the retry rules
    function automatic rsp_t expect_rsp(input plan_t p);
        rsp_t r;
        r.tries   = 2'((p.nack_n < MAX_RETRY) ? p.nack_n : MAX_RETRY);
        r.nack    = p.nack_n > MAX_RETRY;
        r.data    = p.op ? p.rx : 8'h00;
        r.timeout = 1'b0;
        return r;
    endfunction

    function automatic int attempts(input plan_t p);
        return ((p.nack_n < MAX_RETRY) ? p.nack_n : MAX_RETRY) + 1;
    endfunction

    task automatic push_cmd(input plan_t p, input rsp_t e);
        bit rdy;
        int k = 0;
        cmd_valid = 1'b1;
        cmd_op    = p.op;
        cmd_len   = p.len;
        cmd_addr  = p.addr;
        cmd_data  = p.data;
        do begin
            rdy = cmd_ready;
            tick(1);
            k++;
        end while (!rdy && k < 3000);
        cmd_valid = 1'b0;
        if (!rdy) fail_now("push_accept");
        else begin
            plans.push_back(p);
            exp_q.push_back(e);
            push_cyc = cyc;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || plans.size() != 0 || have_cur || ctl_busy) && k < 20000) begin
            tick(1);
            k++;
        end
        if (k >= 20000) fail_now("drain");
    endtask

    task automatic wait_start(input int s0);
        int k = 0;
        while (n_starts == s0 && k < 500) begin
            tick(1);
            k++;
        end
        if (k >= 500) fail_now("wait_start");
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_nack"}, rsp_nack, 0);
        check({tag, "_rsp_tries"}, rsp_tries, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_ctl_start"}, ctl_start, 0);
        check({tag, "_ctl_bus"}, {ctl_op, ctl_len, ctl_addr, ctl_data}, 0);
        check({tag, "_force_clk"}, ctl_force_clk, 0);
    endtask

    // Controller model: one attempt per accepted start, busy for busy_len cycles,
    // NACK on the first nack_n attempts of a command
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ctl_busy = 1'b0;
            ctl_nack = 1'b0;
            have_cur = 0;
            held     = 0;
            continue;
        end
        if (hold) begin
            ctl_busy = 1'b1;
            held     = 1;
            continue;
        end
        if (held) begin
            ctl_busy = 1'b0;
            held     = 0;
            continue;
        end
        if (ctl_busy) begin
            rem--;
            if (rem <= 0) begin
                ctl_busy  = 1'b0;
                ctl_nack  = this_nack;
                ctl_q_rx  = cur.rx;
                last_fall = cyc;
                att++;
                if (!this_nack || att > MAX_RETRY) have_cur = 0;
            end
        end else if (ctl_start) begin
            if (!have_cur) begin
                if (plans.size() == 0) begin
                    fail_now("unexpected_start");
                    continue;
                end
                cur      = plans.pop_front();
                have_cur = 1;
                att      = 0;
            end else check("retry_gap_ok", (cyc - last_fall) >= GAP, 1);
            check("start_addr", ctl_addr, cur.addr);
            check("start_op_len", {ctl_op, ctl_len}, {cur.op, cur.len});
            check("start_data", ctl_data, cur.data);
            n_starts++;
            start_cyc = cyc;
            ctl_busy  = 1'b1;
            rem       = cur.busy_len;
            this_nack = att < cur.nack_n;
            #1;
            check("start_drops_on_busy", ctl_start, 0);
        end
    end

    // Monitor: pops the scoreboard on every result handshake
    initial forever begin
        @(negedge clk);
        rsp_ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_rsp");
            else begin
                mon_e = exp_q.pop_front();
                check("rsp_data", rsp_data, mon_e.data);
                check("rsp_nack", rsp_nack, mon_e.nack);
                check("rsp_tries", rsp_tries, mon_e.tries);
                check("rsp_timeout", rsp_timeout, mon_e.timeout);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        plan_t p;
        rsp_t  e;
        int    s0, es, k;
        tick(3);
        check_reset("reset");
        rst_n = 1'b1;
        tick(2);

        p = '{op:1'b0, len:1'b0, addr:7'h3C, data:8'h5A, rx:8'h11, nack_n:0, busy_len:40};
        s0 = n_starts;
        push_cmd(p, expect_rsp(p));
        wait_start(s0);
        check("start_latency", start_cyc - push_cyc, 2);
        drain();

        p = '{op:1'b1, len:1'b0, addr:7'h48, data:8'h00, rx:8'hA7, nack_n:0, busy_len:12};
        push_cmd(p, expect_rsp(p));
        drain();

        p = '{op:1'b0, len:1'b1, addr:7'h50, data:8'hC3, rx:8'h00, nack_n:3, busy_len:8};
        s0 = n_starts;
        push_cmd(p, expect_rsp(p));
        drain();
        check("nack_attempts", n_starts - s0, MAX_RETRY + 1);

        hold = 1;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            p = '{op:1'(i & 1), len:1'b0, addr:7'(7'h10 + i), data:8'(8'h20 + i),
                  rx:8'(8'h90 + i), nack_n:0, busy_len:4};
            if (i == 4) hold = 0;
            push_cmd(p, expect_rsp(p));
            if (i == 0) check("ready_after_1st", cmd_ready, 1);
            if (i == 3) check("ready_after_4th", cmd_ready, 0);
        end
        drain();

        ready_mode = 0;
        p = '{op:1'b1, len:1'b0, addr:7'h21, data:8'h00, rx:8'h3E, nack_n:1, busy_len:5};
        push_cmd(p, expect_rsp(p));
        e = expect_rsp(p);
        p = '{op:1'b0, len:1'b0, addr:7'h22, data:8'h44, rx:8'h00, nack_n:0, busy_len:5};
        push_cmd(p, expect_rsp(p));
        k = 0;
        while (!rsp_valid && k < 500) begin
            tick(1);
            k++;
        end
        if (k >= 500) fail_now("wait_rsp_valid");
        s0 = n_starts;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("held_rsp", {rsp_valid, rsp_data, rsp_nack, rsp_tries}, {1'b1, e.data, e.nack, e.tries});
        end
        check("no_start_while_held", n_starts - s0, 0);
        ready_mode = 1;
        drain();

        p = '{op:1'b1, len:1'b0, addr:7'h33, data:8'h00, rx:8'h55, nack_n:0, busy_len:100};
        s0 = n_starts;
        push_cmd(p, expect_rsp(p));
        p.addr = 7'h34;
        push_cmd(p, expect_rsp(p));
        wait_start(s0);
        tick(5);
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        plans.delete();
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        s0 = n_starts;
        tick(30);
        check("queue_lost_on_reset", n_starts - s0, 0);

`ifdef I2C_SEQ_TIMEOUT_EN
        p = '{op:1'b1, len:1'b0, addr:7'h66, data:8'h00, rx:8'h77, nack_n:0, busy_len:200};
        e = '{data:8'h00, nack:1'b1, tries:2'd0, timeout:1'b1};
        s0 = n_starts;
        push_cmd(p, e);
        wait_start(s0);
        k = 0;
        while (!ctl_force_clk && k < 300) begin
            tick(1);
            k++;
        end
        if (k >= 300) fail_now("wait_force_clk");
        check("force_clk_cycle", cyc - start_cyc, TO);
        drain();
        check("no_retry_after_timeout", n_starts - s0, 1);
`endif

        ready_mode = 2;
        s0 = n_starts;
        es = 0;
        for (int i = 0; i < 24; i++) begin
            p.op       = 1'($urandom_range(0, 1));
            p.len      = 1'($urandom_range(0, 1));
            p.addr     = 7'($urandom_range(0, 127));
            p.data     = 8'($urandom_range(0, 255));
            p.rx       = 8'($urandom_range(0, 255));
            p.nack_n   = $urandom_range(0, 3);
            p.busy_len = $urandom_range(2, 12);
            es += attempts(p);
            push_cmd(p, expect_rsp(p));
            tick($urandom_range(0, 3));
        end
        drain();
        check("random_attempts", n_starts - s0, es);
        ready_mode = 1;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Command front-end that sits directly upstream of the I2C controller. It buffers I2C transactions in a small FIFO, issues each one to the controller with a start/busy handshake, and retries transactions that end in NACK. It captures read data and status into a result port with a valid/ready handshake. The block lets firmware or a fabric master queue several transfers without polling the controller's BUSY line.

Parameters:
NUM_BYTES, 1, payload bytes per transaction; data width is 8*NUM_BYTES
DEPTH, 4, command FIFO entries; must be a power of 2 and at least 2
MAX_RETRY, 2, re-issues allowed after a NACK (0 disables retry)
GAP_CYCLES, 16, idle clk cycles between a NACKed attempt and its retry
TIMEOUT_CYCLES, 4096, watchdog limit per attempt (used only with I2C_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock; same clock as the controller
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  1  0 = write, 1 = read
cmd_len  in  1  0 = one byte, 1 = two bytes
cmd_addr  in  7  7-bit peripheral address
cmd_data  in  8*NUM_BYTES  write payload
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed
rsp_data  out  8*NUM_BYTES  read data; zero for writes
rsp_nack  out  1  final attempt was NACKed
rsp_tries  out  2  attempts used minus 1 (saturates at 3)
rsp_timeout  out  1  attempt aborted by watchdog
ctl_start  out  1  to controller start
ctl_op  out  1  to controller op code
ctl_len  out  1  to controller byte-count select
ctl_addr  out  7  to controller address
ctl_data  out  8*NUM_BYTES  to controller TX data
ctl_force_clk  out  1  to controller bus-clear input
ctl_busy  in  1  from controller busy flag
ctl_nack  in  1  from controller NACK flag
ctl_q_rx  in  8*NUM_BYTES  from controller RX data

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1; FIFO empty; FSM in IDLE; retry counter 0.
- Reset is asynchronous and takes effect mid-transaction. The block does not wait for ctl_busy to fall, and the queued commands are lost.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = (count != DEPTH), taken from registered count only. A pop in the same cycle does not raise cmd_ready.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, LOAD, ISSUE, WAIT_DONE, GAP, FLUSH, REPORT.
- IDLE: if the FIFO is non-empty and ctl_busy = 0, pop the head into the working registers (ctl_op/len/addr/data, which stay stable until REPORT), clear the retry counter, and go to LOAD.
- LOAD: one cycle so the ctl_* buses settle, then go to ISSUE.
- ISSUE: hold ctl_start = 1 until ctl_busy is sampled high, then drop ctl_start in that cycle and go to WAIT_DONE. Latency from pop to ctl_start is 2 clk.
- WAIT_DONE: wait for ctl_busy = 0. In that cycle sample ctl_nack and ctl_q_rx.
  - If there is no NACK, or retries = MAX_RETRY: load the rsp_* registers and go to REPORT.
  - Otherwise: increment retries and go to GAP.
- GAP: count GAP_CYCLES clk, then go to ISSUE (same working registers).
- REPORT: rsp_valid = 1 and rsp_* are held stable until rsp_ready.
  - On handshake, drop rsp_valid the next cycle and go to IDLE.
  - A new command cannot be issued while a result is unconsumed.
- rsp_data = captured ctl_q_rx when op = 1, else 0.
- rsp_tries = retry count.
- rsp_nack = 1 only when the final attempt NACKed.

Optional Feature:
I2C_SEQ_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to ISSUE and counts in ISSUE and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: drop ctl_start, enter FLUSH, and hold ctl_force_clk = 1 until ctl_busy = 0 or a further TIMEOUT_CYCLES elapse.
  - Then go to REPORT with rsp_timeout = 1, rsp_nack = 1, rsp_data = 0. No retry follows a timeout.
- When undefined: no counter and no FLUSH path; ctl_force_clk and rsp_timeout are tied to 0.

Test Plan:
- Write 0x5A to addr 0x3C; controller model busy for 40 cycles, no NACK -> ctl_start rises 2 clk after push and falls when busy rises. Result: rsp_valid, rsp_nack = 0, rsp_tries = 0, rsp_data = 0.
- Read from 0x48; model returns 0xA7 -> rsp_data = 0xA7, rsp_nack = 0, rsp_tries = 0.
- NACK on every attempt with MAX_RETRY = 2 -> exactly 3 ctl_start pulses, each separated by at least 16 clk of GAP. Result: rsp_nack = 1, rsp_tries = 2.
- Push 5 commands back-to-back with DEPTH = 4 while the model is held busy -> cmd_ready falls after the 4th push. After drain, results appear in push order with matching addresses.
- Hold rsp_ready = 0 for 100 cycles -> rsp_* stay stable and no further ctl_start occurs. Assert rst_n low mid-WAIT_DONE -> all outputs return to reset values asynchronously.
- With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 64, model busy stuck high -> ctl_force_clk rises at cycle 64 of the attempt. Result: rsp_timeout = 1, no retry.
